// File: rtl/johnson_dec.sv
// Registered Johnson-code decoder with step pulse and sticky integrity flag.
// Optional one-hot phase output enabled by defining JOHNSON_DEC_ONEHOT_EN.
module johnson_dec #(
    parameter int n = 8,
    localparam int w = $clog2(2*n)
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic [n-1:0] in,
    input  logic         err_clr,
    output logic [w-1:0] out,
    output logic         valid,
    output logic         step,
    output logic         err
`ifdef JOHNSON_DEC_ONEHOT_EN
    ,
    output logic [2*n-1:0] phase
`endif
);

    logic [n-1:0] s1;
    logic         s1v;
    logic [w-1:0] p;
    logic         pv;

    logic [n-1:0] s1_inc, inv, inv_inc;
    logic         legal;
    logic [w-1:0] idx, p_inc;
    logic         fault;
    int           ones;
    int           idx_i;

    // Legal words are a run of ones touching bit 0, or a run of zeros touching bit 0.
    always_comb begin
        s1_inc  = s1 + n'(1);
        inv     = ~s1;
        inv_inc = inv + n'(1);
        legal   = ((s1 & s1_inc) == '0) || ((inv & inv_inc) == '0);
        ones    = 0;
        for (int i = 0; i < n; i++) begin
            if (s1[i]) ones++;
        end
        idx_i   = s1[n-1] ? ((2*n - ones) % (2*n)) : ones;
        idx     = w'(idx_i);
        p_inc   = (p == w'(2*n - 1)) ? '0 : p + w'(1);
        fault   = s1v && (!legal || (pv && idx != p && idx != p_inc));
    end

    // s1v keeps the reset value of s1 from being decoded as a real sample.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            s1    <= '0;
            s1v   <= 1'b0;
            p     <= '0;
            pv    <= 1'b0;
            out   <= '0;
            valid <= 1'b0;
            step  <= 1'b0;
            err   <= 1'b0;
        end else begin
            s1  <= in;
            s1v <= 1'b1;
            if (s1v) begin
                if (legal) begin
                    out   <= idx;
                    valid <= 1'b1;
                    step  <= pv && (idx == p_inc);
                    p     <= idx;
                    pv    <= 1'b1;
                end else begin
                    valid <= 1'b0;
                    step  <= 1'b0;
                    pv    <= 1'b0;
                end
            end
            err <= fault | (err & ~err_clr);
        end
    end

`ifdef JOHNSON_DEC_ONEHOT_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            phase <= '0;
        end else if (s1v) begin
            phase <= legal ? ((2*n)'(1) << idx) : '0;
        end
    end
`endif

endmodule

// File: tb/tb_johnson_dec.sv
// Bench for johnson_dec: directed scenarios plus random stepping checked
// against a table-lookup reference model (n=3), and a directed n=4 hold case.
module tb_johnson_dec;
    localparam int N = 3;
    localparam int M = 2 * N;

    logic       clk = 1'b0;
    logic       clr_n = 1'b1;
    logic       err_clr = 1'b0;
    logic       clr4 = 1'b0;
    logic [2:0] in3 = '0;
    logic [3:0] in4 = '0;
    logic [2:0] out3, out4;
    logic       v3, s3, e3, v4, s4, e4;
`ifdef JOHNSON_DEC_ONEHOT_EN
    logic [5:0] phase3;
    logic [7:0] phase4;
`endif

    johnson_dec #(.n(3)) d3 (
        .clk(clk), .clr_n(clr_n), .in(in3), .err_clr(err_clr),
        .out(out3), .valid(v3), .step(s3), .err(e3)
`ifdef JOHNSON_DEC_ONEHOT_EN
        , .phase(phase3)
`endif
    );

    johnson_dec #(.n(4)) d4 (
        .clk(clk), .clr_n(clr_n), .in(in4), .err_clr(clr4),
        .out(out4), .valid(v4), .step(s4), .err(e4)
`ifdef JOHNSON_DEC_ONEHOT_EN
        , .phase(phase4)
`endif
    );

    // clock/reset block
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    int n_assert = 0;
    int n_fail = 0;

    // reference model: code table built by running a Johnson counter
    logic [2:0] jtab[M];
    logic [2:0] m_s1;
    bit         m_s1v, m_pv, m_valid, m_step, m_err;
    int         m_p, m_out;
    logic [5:0] exp_q[$];

    function automatic int lookup(logic [2:0] c);
        for (int k = 0; k < M; k++) if (jtab[k] === c) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s1v = 0; m_pv = 0; m_valid = 0; m_step = 0; m_err = 0;
        m_p = 0; m_out = 0;
    endtask

    task automatic model_edge(logic [2:0] x, bit c);
        bit fault = 0;
        int k;
        if (m_s1v) begin
            k = lookup(m_s1);
            if (k < 0) begin
                m_valid = 0; m_step = 0; m_pv = 0; fault = 1;
            end else begin
                if (m_pv && k != m_p && k != (m_p + 1) % M) fault = 1;
                m_step = m_pv && (k == (m_p + 1) % M);
                m_out = k; m_valid = 1; m_p = k; m_pv = 1;
            end
        end
        m_err = fault | (m_err & !c);
        m_s1 = x;
        m_s1v = 1;
    endtask

    // scoreboard
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [5:0] e;
        exp_q.push_back({3'(m_out), m_valid, m_step, m_err});
        e = exp_q.pop_front();
        check("out", 32'(out3), 32'(e[5:3]));
        check("valid", 32'(v3), 32'(e[2]));
        check("step", 32'(s3), 32'(e[1]));
        check("err", 32'(e3), 32'(e[0]));
`ifdef JOHNSON_DEC_ONEHOT_EN
        check("phase", 32'(phase3), m_valid ? (32'(1) << m_out) : 32'(0));
`endif
    endtask

    // driver tasks
    task automatic tick(logic [2:0] x, logic [3:0] y, bit c);
        in3 = x;
        in4 = y;
        err_clr = c;
        @(posedge clk);
        model_edge(x, c);
        #1;
        check_all();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        clr_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("out4_rst", 32'(out4), 32'(0));
        check("err4_rst", 32'(e4), 32'(0));
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    initial begin
        int seq[9]  = '{0, 1, 3, 7, 6, 4, 0, 1, 3};
        int oseq[8] = '{0, 1, 2, 3, 4, 5, 0, 1};
        logic [2:0] cur;
        int k;
        int r;
        logic [2:0] x;

        cur = '0;
        for (int i = 0; i < M; i++) begin
            jtab[i] = cur;
            cur = {cur[1:0], ~cur[2]};
        end

        // full forward sequence
        reset_dut();
        for (int t = 1; t <= 9; t++) begin
            tick(3'(seq[t-1]), 4'h0, 1'b0);
            if (t >= 2) begin
                check("seq_out", 32'(out3), 32'(oseq[t-2]));
                check("seq_step", 32'(s3), 32'(t > 2));
                check("seq_err", 32'(e3), 32'(0));
            end
        end

        // illegal word then recovery
        reset_dut();
        tick(3'b011, 4'h0, 1'b0);
        tick(3'b101, 4'h0, 1'b0);
        check("ill_pre_out", 32'(out3), 32'(2));
        tick(3'b111, 4'h0, 1'b0);
        check("ill_valid", 32'(v3), 32'(0));
        check("ill_out_hold", 32'(out3), 32'(2));
        check("ill_err", 32'(e3), 32'(1));
        tick(3'b111, 4'h0, 1'b0);
        check("rec_out", 32'(out3), 32'(3));
        check("rec_step", 32'(s3), 32'(0));
        check("rec_err_sticky", 32'(e3), 32'(1));

        // skip, then err_clr with legal stepping
        reset_dut();
        tick(3'b001, 4'h0, 1'b0);
        tick(3'b111, 4'h0, 1'b0);
        tick(3'b110, 4'h0, 1'b0);
        check("skip_out", 32'(out3), 32'(3));
        check("skip_step", 32'(s3), 32'(0));
        check("skip_err", 32'(e3), 32'(1));
        tick(3'b100, 4'h0, 1'b1);
        check("clr_err", 32'(e3), 32'(0));
        check("clr_step", 32'(s3), 32'(1));

        // err_clr coincident with a skip 111 -> 100
        reset_dut();
        tick(3'b011, 4'h0, 1'b0);
        tick(3'b111, 4'h0, 1'b0);
        tick(3'b100, 4'h0, 1'b0);
        tick(3'b100, 4'h0, 1'b1);
        check("clrskip_err", 32'(e3), 32'(1));
        check("clrskip_out", 32'(out3), 32'(5));

        // n=4 hold then single advance
        reset_dut();
        for (int t = 1; t <= 9; t++) begin
            tick(3'b000, (t <= 6) ? 4'b1100 : 4'b1000, 1'b0);
            if (t >= 2) begin
                check("n4_out", 32'(out4), (t <= 7) ? 32'(6) : 32'(7));
                check("n4_step", 32'(s4), 32'(t == 8));
                check("n4_err", 32'(e4), 32'(0));
            end
        end

        // asynchronous reset mid-sequence
        reset_dut();
        tick(3'b000, 4'h0, 1'b0);
        tick(3'b001, 4'h0, 1'b0);
        tick(3'b011, 4'h0, 1'b0);
        tick(3'b111, 4'h0, 1'b0);
        tick(3'b110, 4'h0, 1'b0);
        tick(3'b110, 4'h0, 1'b0);
        check("mid_out", 32'(out3), 32'(4));
        #2;
        clr_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("arst_out", 32'(out3), 32'(0));
        check("arst_valid", 32'(v3), 32'(0));
        @(negedge clk);
        clr_n = 1'b1;
        tick(3'b110, 4'h0, 1'b0);
        tick(3'b110, 4'h0, 1'b0);
        check("post_valid", 32'(v3), 32'(1));
        check("post_step", 32'(s3), 32'(0));
        check("post_err", 32'(e3), 32'(0));

        // random stepping with occasional faults and clears
        reset_dut();
        k = 0;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 19));
            if (r < 12) k = (k + 1) % M;
            else if (r < 17) k = int'($urandom_range(0, M - 1));
            x = jtab[k];
            if (r >= 17 && r < 19) x = 3'($urandom_range(0, 7));
            tick(x, 4'h0, $urandom_range(0, 7) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
